// File: rtl/compare_round_sched.sv
// compare_round_sched
// Sequences one comparison round at a time across two redundant modules:
// request both, collect both results under a timeout, compare, and track the
// mismatch count. Drives the output-disable level and the sticky lock flag
// used by the relay/switch output stage.
//
// Build option:
//   ERR_DECAY_EN  defined   -> a passing round clears errorCount, so LOCK needs
//                              MAX_ERR consecutive mismatches.
//                 undefined -> errorCount is cumulative until rst.
module compare_round_sched #(
    parameter int unsigned TIMEOUT_CYC = 10000000,
    parameter int unsigned PERIOD_CYC  = 1000,
    parameter int unsigned MAX_ERR     = 3,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              enable,
    output logic              reqMod1,
    output logic              reqMod2,
    input  logic              ackMod1,
    input  logic              ackMod2,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    output logic              roundValid,
    output logic              roundPass,
    output logic [3:0]        errorCount,
    output logic              outputDis,
    output logic              timeOut,
    output logic              locked
);

    // Last WAIT count before the round is declared timed out, and last GAP count.
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [3:0]  ERR_LIM  = 4'(MAX_ERR);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        GAP  = 3'd4,
        LOCK = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              req1_q, req1_d;
    logic              req2_q, req2_d;
    logic              flag1_q, flag1_d;
    logic              flag2_q, flag2_d;
    logic [DATA_W-1:0] res1_q, res1_d;
    logic [DATA_W-1:0] res2_q, res2_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              rv_q, rv_d;
    logic              rp_q, rp_d;
    logic [3:0]        err_q, err_d;
    logic              dis_q, dis_d;
    logic              to_q, to_d;
    logic              lock_q, lock_d;

    // Mismatch counter increment, holding at the 4-bit ceiling.
    function automatic logic [3:0] err_inc(input logic [3:0] e);
        return (e == 4'hF) ? 4'hF : (e + 4'd1);
    endfunction

    // Next-state and registered-output logic for the round sequencer.
    always_comb begin
        state_d = state_q;
        req1_d  = req1_q;
        req2_d  = req2_q;
        flag1_d = flag1_q;
        flag2_d = flag2_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        cnt_d   = cnt_q;
        rv_d    = 1'b0;
        rp_d    = rp_q;
        err_d   = err_q;
        dis_d   = dis_q;
        to_d    = to_q;
        lock_d  = lock_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                req1_d  = 1'b1;
                req2_d  = 1'b1;
                flag1_d = 1'b0;
                flag2_d = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                // An ack only counts while its request is still outstanding,
                // so late or stray acks cannot overwrite a captured result.
                if (ackMod1 && req1_q) begin
                    res1_d  = result1;
                    flag1_d = 1'b1;
                    req1_d  = 1'b0;
                end
                if (ackMod2 && req2_q) begin
                    res2_d  = result2;
                    flag2_d = 1'b1;
                    req2_d  = 1'b0;
                end
                cnt_d = cnt_q + 32'd1;
                // Completion wins over a timeout landing in the same cycle.
                if (flag1_d && flag2_d) begin
                    cnt_d   = '0;
                    state_d = CMP;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    req1_d  = 1'b0;
                    req2_d  = 1'b0;
                    dis_d   = 1'b1;
                    lock_d  = 1'b1;
                    state_d = LOCK;
                end
            end

            CMP: begin
                rv_d  = 1'b1;
                rp_d  = (res1_q == res2_q);
                cnt_d = '0;
                if (res1_q == res2_q) begin
                    dis_d   = 1'b0;
`ifdef ERR_DECAY_EN
                    err_d   = 4'd0;
`else
                    err_d   = err_q;
`endif
                    state_d = GAP;
                end else begin
                    err_d = err_inc(err_q);
                    if (err_d >= ERR_LIM) begin
                        dis_d   = 1'b1;
                        lock_d  = 1'b1;
                        state_d = LOCK;
                    end else begin
                        state_d = GAP;
                    end
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? REQ : IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            LOCK: begin
                req1_d = 1'b0;
                req2_d = 1'b0;
                dis_d  = 1'b1;
                lock_d = 1'b1;
            end

            default: begin
                // Corrupted state register: fall into the safe, locked state.
                req1_d  = 1'b0;
                req2_d  = 1'b0;
                dis_d   = 1'b1;
                lock_d  = 1'b1;
                state_d = LOCK;
            end
        endcase
    end

    // State and output registers; reset returns everything to the safe idle state.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
            flag1_q <= 1'b0;
            flag2_q <= 1'b0;
            res1_q  <= '0;
            res2_q  <= '0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            rp_q    <= 1'b0;
            err_q   <= 4'd0;
            dis_q   <= 1'b1;
            to_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req1_q  <= req1_d;
            req2_q  <= req2_d;
            flag1_q <= flag1_d;
            flag2_q <= flag2_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rp_q    <= rp_d;
            err_q   <= err_d;
            dis_q   <= dis_d;
            to_q    <= to_d;
            lock_q  <= lock_d;
        end
    end

    assign reqMod1    = req1_q;
    assign reqMod2    = req2_q;
    assign roundValid = rv_q;
    assign roundPass  = rp_q;
    assign errorCount = err_q;
    assign outputDis  = dis_q;
    assign timeOut    = to_q;
    assign locked     = lock_q;

endmodule

// File: tb/tb_compare_round_sched.sv
// Bench for compare_round_sched: directed rounds with a behavioural model of the
// expected outputs, checked every cycle, plus hand-computed literal checkpoints.
module tb_compare_round_sched;

    localparam int TO = 100;
    localparam int P  = 4;
    localparam int ME = 3;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       enable;
    logic       reqMod1, reqMod2;
    logic       ackMod1, ackMod2;
    logic [7:0] result1, result2;
    logic       roundValid, roundPass;
    logic [3:0] errorCount;
    logic       outputDis, timeOut, locked;

    compare_round_sched #(
        .TIMEOUT_CYC(TO),
        .PERIOD_CYC (P),
        .MAX_ERR    (ME),
        .DATA_W     (8)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .enable    (enable),
        .reqMod1   (reqMod1),
        .reqMod2   (reqMod2),
        .ackMod1   (ackMod1),
        .ackMod2   (ackMod2),
        .result1   (result1),
        .result2   (result2),
        .roundValid(roundValid),
        .roundPass (roundPass),
        .errorCount(errorCount),
        .outputDis (outputDis),
        .timeOut   (timeOut),
        .locked    (locked)
    );

    always #5 clk1 = ~clk1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model of what the outputs must be in the current cycle.
    int   m_err;
    logic m_dis, m_lock, m_to, m_rv, m_rp, m_req1, m_req2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err  = 0;
        m_dis  = 1'b1;
        m_lock = 1'b0;
        m_to   = 1'b0;
        m_rv   = 1'b0;
        m_rp   = 1'b0;
        m_req1 = 1'b0;
        m_req2 = 1'b0;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk1);
        #1;
        m_rv = 1'b0;
    endtask

    task automatic reset_dut();
        ackMod1 = 1'b0;
        ackMod2 = 1'b0;
        rst = 1'b1;
        tick();
        model_reset();
        rst = 1'b0;
    endtask

    // One round. lat = cycles until the first cycle with requests high (k=0).
    // dN = request-relative cycle of ackN (<0: never). Each ack is repeated one
    // cycle later with a wrong value, which must be ignored.
    task automatic do_round(input int lat, input int d1, input int d2,
                            input logic [7:0] r1, input logic [7:0] r2,
                            input int drop_at, input int rst_at);
        bit tmo;
        int dmax;
        tmo  = (d1 < 0) || (d2 < 0);
        dmax = (d1 > d2) ? d1 : d2;
        repeat (lat - 1) tick();
        for (int k = 0; k <= TO + 2; k++) begin
            tick();
            if (tmo && k == TO) begin
                ackMod1 = 1'b0;
                ackMod2 = 1'b0;
                m_req1  = 1'b0;
                m_req2  = 1'b0;
                m_to    = 1'b1;
                m_lock  = 1'b1;
                m_dis   = 1'b1;
                return;
            end
            m_req1 = (d1 < 0) || (k <= d1);
            m_req2 = (d2 < 0) || (k <= d2);
            if (k == drop_at) enable = 1'b0;
            ackMod1 = (d1 >= 0) && (k == d1 || k == d1 + 1);
            ackMod2 = (d2 >= 0) && (k == d2 || k == d2 + 1);
            result1 = (k == d1) ? r1 : ~r1;
            result2 = (k == d2) ? r2 : ~r2;
            if (k == rst_at) begin
                reset_dut();
                return;
            end
            if (!tmo && k == dmax + 2) begin
                m_rv = 1'b1;
                m_rp = (r1 == r2);
                if (r1 == r2) begin
                    m_dis = 1'b0;
`ifdef ERR_DECAY_EN
                    m_err = 0;
`endif
                end else begin
                    if (m_err < 15) m_err++;
                    if (m_err >= ME) begin
                        m_dis  = 1'b1;
                        m_lock = 1'b1;
                    end
                end
                return;
            end
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk1) begin
        if (chk_en) begin
            chk("roundValid", 32'(roundValid), 32'(m_rv));
            if (m_rv) chk("roundPass", 32'(roundPass), 32'(m_rp));
            chk("errorCount", 32'(errorCount), 32'(m_err));
            chk("outputDis", 32'(outputDis), 32'(m_dis));
            chk("timeOut", 32'(timeOut), 32'(m_to));
            chk("locked", 32'(locked), 32'(m_lock));
            chk("reqMod1", 32'(reqMod1), 32'(m_req1));
            chk("reqMod2", 32'(reqMod2), 32'(m_req2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; ackMod1 = 1'b0; ackMod2 = 1'b0;
        result1 = '0; result2 = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_outputDis", 32'(outputDis), 32'd1);
        chk("rst_errorCount", 32'(errorCount), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_timeOut", 32'(timeOut), 32'd0);
        repeat (3) tick();

        // Basic passing round, acks after 5 cycles.
        enable = 1'b1;
        do_round(2, 5, 5, 8'hA5, 8'hA5, -1, -1);
        chk("t1_roundValid", 32'(roundValid), 32'd1);
        chk("t1_roundPass", 32'(roundPass), 32'd1);
        chk("t1_outputDis", 32'(outputDis), 32'd0);
        chk("t1_errorCount", 32'(errorCount), 32'd0);
        enable = 1'b0;
        repeat (P + 3) tick();

        // Uneven acks, enable dropped mid-round; round still compared, then IDLE.
        enable = 1'b1;
        do_round(2, 3, 9, 8'h3C, 8'h3C, 5, -1);
        chk("t5_roundValid", 32'(roundValid), 32'd1);
        chk("t5_roundPass", 32'(roundPass), 32'd1);
        repeat (P + 3) tick();
        chk("t5_idle_req", 32'(reqMod1), 32'd0);

        // Mismatch, pass (ack2 on the timeout cycle), mismatch, mismatch.
        enable = 1'b1;
        do_round(2, 1, 2, 8'h40, 8'h41, -1, -1);
        chk("t3_err1", 32'(errorCount), 32'd1);
        do_round(P + 1, 0, TO - 1, 8'h5A, 8'h5A, -1, -1);
        chk("t3_late_pass", 32'(roundPass), 32'd1);
        do_round(P + 1, 4, 4, 8'h00, 8'hFF, -1, -1);
        do_round(P + 1, 6, 2, 8'h80, 8'h01, -1, -1);
        enable = 1'b0;
`ifdef ERR_DECAY_EN
        chk("t3_errorCount", 32'(errorCount), 32'd2);
        chk("t3_locked", 32'(locked), 32'd0);
`else
        chk("t3_errorCount", 32'(errorCount), 32'd3);
        chk("t3_locked", 32'(locked), 32'd1);
`endif
        repeat (P + 3) tick();
        reset_dut();

        // Three mismatches 11 vs 12 -> lock on the third.
        enable = 1'b1;
        do_round(2, 2, 0, 8'h11, 8'h12, -1, -1);
        chk("t2_err1", 32'(errorCount), 32'd1);
        do_round(P + 1, 0, 0, 8'h11, 8'h12, -1, -1);
        chk("t2_err2", 32'(errorCount), 32'd2);
        do_round(P + 1, 1, 4, 8'h11, 8'h12, -1, -1);
        chk("t2_err3", 32'(errorCount), 32'd3);
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_outputDis", 32'(outputDis), 32'd1);
        // LOCK ignores enable and acks.
        for (int i = 0; i < 12; i++) begin
            tick();
            ackMod1 = i[0];
            ackMod2 = ~i[0];
        end
        ackMod1 = 1'b0;
        ackMod2 = 1'b0;
        chk("t2_no_req", 32'(reqMod1), 32'd0);

        // Reset during LOCK, then reset during WAIT, then a clean round.
        reset_dut();
        chk("t6_locked", 32'(locked), 32'd0);
        chk("t6_outputDis", 32'(outputDis), 32'd1);
        chk("t6_errorCount", 32'(errorCount), 32'd0);
        do_round(2, -1, -1, 8'h00, 8'h00, -1, 3);
        chk("t6_wait_rst_req", 32'(reqMod1), 32'd0);
        do_round(2, 2, 3, 8'hC3, 8'hC3, -1, -1);
        chk("t6_pass", 32'(roundPass), 32'd1);

        // ackMod2 never arrives -> timeout after TO WAIT cycles.
        do_round(P + 1, 1, -1, 8'h77, 8'h77, -1, -1);
        chk("t4_timeOut", 32'(timeOut), 32'd1);
        chk("t4_locked", 32'(locked), 32'd1);
        chk("t4_reqMod2", 32'(reqMod2), 32'd0);
        repeat (10) tick();

        enable = 1'b0;
        reset_dut();
        chk("end_timeOut", 32'(timeOut), 32'd0);
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
